// File: rtl/monster_mode_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : monster_mode_ctrl_pkg
// Brief  : Mode encoding and default frame constants for the monster mode
//          sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package monster_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    FRIGHT = 2'd1,
    FLASH  = 2'd2,
    EATEN  = 2'd3
  } monster_mode_t;

  // Default timing in video frames
  localparam int unsigned DEF_FRIGHT_FRAMES  = 360;
  localparam int unsigned DEF_FLASH_FRAMES   = 120;
  localparam int unsigned DEF_FLASH_PERIOD   = 8;
  localparam int unsigned DEF_RESPAWN_FRAMES = 180;
  localparam int unsigned DEF_CNT_W          = 10;

endpackage
`default_nettype wire

// File: rtl/monster_mode_ctrl_frame_timer.sv
`default_nettype none
// ============================================================================
// Module : monster_mode_ctrl_frame_timer
// Brief  : Loadable frame down-counter. Expiry is the tick seen while the
//          count is 1, so a load of N expires on the N-th tick.
// Rev    : 1.0  initial release
// ============================================================================
module monster_mode_ctrl_frame_timer #(
  parameter int unsigned CNT_W = 10
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  input  logic             tick_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] count_q;

  // Load has priority over the tick; the counter parks at zero when idle
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (tick_i && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign expire_o = tick_i && (count_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/monster_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module : monster_mode_ctrl
// Brief  : Per-monster mode sequencer (NORMAL / FRIGHT / FLASH / EATEN),
//          timed in video frames. Drives image select, visibility and the
//          collision outcome pulses. All outputs are registered.
// Rev    : 1.0  initial release
// ============================================================================
module monster_mode_ctrl
  import monster_mode_ctrl_pkg::*;
#(
  parameter int unsigned FRIGHT_FRAMES  = DEF_FRIGHT_FRAMES,
  parameter int unsigned FLASH_FRAMES   = DEF_FLASH_FRAMES,
  parameter int unsigned FLASH_PERIOD   = DEF_FLASH_PERIOD,
  parameter int unsigned RESPAWN_FRAMES = DEF_RESPAWN_FRAMES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame_i,
  input  logic       powerPillEaten_i,
  input  logic       collisionPacman_i,
  input  logic       gameRestart_i,
  output logic       shiftImage_o,
  output logic       monsterVisible_o,
  output logic       frightened_o,
  output logic       monsterEaten_o,
  output logic       pacmanKilled_o,
  output logic [1:0] modeState_o
);

  localparam logic [CNT_W-1:0] STEADY_LOAD  = CNT_W'(FRIGHT_FRAMES - FLASH_FRAMES);
  localparam logic [CNT_W-1:0] FLASH_LOAD   = CNT_W'(FLASH_FRAMES);
  localparam logic [CNT_W-1:0] RESPAWN_LOAD = CNT_W'(RESPAWN_FRAMES);
  localparam logic [CNT_W-1:0] PHASE_LAST   = CNT_W'(FLASH_PERIOD - 1);

  monster_mode_t    state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic             shift_q, shift_d;
  logic             visible_q, visible_d;
  logic             fright_q, fright_d;
  logic             eaten_q, eaten_d;
  logic             killed_q, killed_d;
  logic             load_d;
  logic [CNT_W-1:0] load_val_d;
  logic             expire;

  // Single timer shared by FRIGHT, FLASH and EATEN
  monster_mode_ctrl_frame_timer #(
    .CNT_W (CNT_W)
  ) u_frame_timer (
    .clk      (clk),
    .resetN   (resetN),
    .load_i   (load_d),
    .value_i  (load_val_d),
    .tick_i   (startOfFrame_i),
    .expire_o (expire)
  );

  // State and output registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= NORMAL;
      phase_q   <= '0;
      shift_q   <= 1'b0;
      visible_q <= 1'b1;
      fright_q  <= 1'b0;
      eaten_q   <= 1'b0;
      killed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      shift_q   <= shift_d;
      visible_q <= visible_d;
      fright_q  <= fright_d;
      eaten_q   <= eaten_d;
      killed_q  <= killed_d;
    end
  end

  // Next-state: restart > collision > pill > frame tick
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    shift_d    = shift_q;
    visible_d  = visible_q;
    eaten_d    = 1'b0;
    killed_d   = 1'b0;
    load_d     = 1'b0;
    load_val_d = '0;

    if (gameRestart_i) begin
      state_d   = NORMAL;
      phase_d   = '0;
      shift_d   = 1'b0;
      visible_d = 1'b1;
      load_d    = 1'b1;
    end else begin
      case (state_q)
        NORMAL: begin
          shift_d   = 1'b0;
          visible_d = 1'b1;
          if (collisionPacman_i) begin
            killed_d = 1'b1;
          end else if (powerPillEaten_i) begin
            state_d    = FRIGHT;
            shift_d    = 1'b1;
            load_d     = 1'b1;
            load_val_d = STEADY_LOAD;
          end
        end
        FRIGHT, FLASH: begin
          if (collisionPacman_i) begin
            state_d    = EATEN;
            shift_d    = 1'b0;
            visible_d  = 1'b0;
            eaten_d    = 1'b1;
            load_d     = 1'b1;
            load_val_d = RESPAWN_LOAD;
          end else if (powerPillEaten_i) begin
            state_d    = FRIGHT;
            shift_d    = 1'b1;
            load_d     = 1'b1;
            load_val_d = STEADY_LOAD;
          end else if (state_q == FRIGHT) begin
            if (expire) begin
              state_d    = FLASH;
              phase_d    = '0;
              shift_d    = 1'b1;
              load_d     = 1'b1;
              load_val_d = FLASH_LOAD;
            end
          end else if (startOfFrame_i) begin
            if (expire) begin
              state_d = NORMAL;
              shift_d = 1'b0;
            end else if (phase_q == PHASE_LAST) begin
              shift_d = ~shift_q;
              phase_d = '0;
            end else begin
              phase_d = phase_q + CNT_W'(1);
            end
          end
        end
        EATEN: begin
          shift_d   = 1'b0;
          visible_d = 1'b0;
          if (expire) begin
            state_d   = NORMAL;
            visible_d = 1'b1;
          end
        end
        default: state_d = NORMAL;
      endcase
    end

    fright_d = (state_d == FRIGHT) || (state_d == FLASH);
  end

  assign modeState_o      = state_q;
  assign shiftImage_o     = shift_q;
  assign monsterVisible_o = visible_q;
  assign frightened_o     = fright_q;
  assign monsterEaten_o   = eaten_q;
  assign pacmanKilled_o   = killed_q;

endmodule
`default_nettype wire

// File: tb/tb_monster_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_monster_mode_ctrl
// Brief  : Self-checking bench: directed vector table, async-reset sequence
//          and randomized traffic against a frame-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_monster_mode_ctrl;

  localparam int FR = 10;
  localparam int FL = 4;
  localparam int FP = 2;
  localparam int RS = 3;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       sof = 1'b0, pill = 1'b0, col = 1'b0, rst = 1'b0;
  logic       shiftImage, monsterVisible, frightened, monsterEaten, pacmanKilled;
  logic [1:0] modeState;

  int tests = 0;
  int fails = 0;

  monster_mode_ctrl #(
    .FRIGHT_FRAMES  (FR),
    .FLASH_FRAMES   (FL),
    .FLASH_PERIOD   (FP),
    .RESPAWN_FRAMES (RS),
    .CNT_W          (10)
  ) dut (
    .clk               (clk),
    .resetN            (resetN),
    .startOfFrame_i    (sof),
    .powerPillEaten_i  (pill),
    .collisionPacman_i (col),
    .gameRestart_i     (rst),
    .shiftImage_o      (shiftImage),
    .monsterVisible_o  (monsterVisible),
    .frightened_o      (frightened),
    .monsterEaten_o    (monsterEaten),
    .pacmanKilled_o    (pacmanKilled),
    .modeState_o       (modeState)
  );

  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       sof, pill, col, rst;
    logic [1:0] st;
    logic       sh, vis, ea, ki;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(input logic s, p, c, r, input logic [1:0] st,
                               input logic sh, vis, ea, ki);
    row = '{sof: s, pill: p, col: c, rst: r, st: st, sh: sh, vis: vis, ea: ea, ki: ki};
  endfunction

  function automatic logic [6:0] exp_of(input vec_t v);
    exp_of = {v.st, v.sh, v.vis, (v.st == 2'd1) || (v.st == 2'd2), v.ea, v.ki};
  endfunction

  function automatic logic [6:0] actual();
    actual = {modeState, shiftImage, monsterVisible, frightened, monsterEaten, pacmanKilled};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got {st,sh,vis,fr,ea,ki}=%b_%b%b%b%b%b want %b_%b%b%b%b%b", name,
               act[6:5], act[4], act[3], act[2], act[1], act[0],
               exp[6:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input logic s, p, c, r);
    @(negedge clk);
    sof = s; pill = p; col = c; rst = r;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Tracks mode, frames remaining in the current timed mode, and frames
  // elapsed in flashing; the image in flashing follows from elapsed/period.
  int m_mode, m_rem, m_el;
  bit m_ea, m_ki;

  task automatic model_reset();
    m_mode = 0; m_rem = 0; m_el = 0; m_ea = 0; m_ki = 0;
  endtask

  task automatic model_step(input bit s, p, c, r);
    m_ea = 0; m_ki = 0;
    if (r) begin
      model_reset();
    end else if (m_mode == 3) begin
      if (s) begin
        if (m_rem == 1) m_mode = 0;
        m_rem--;
      end
    end else if (c) begin
      if (m_mode == 0) m_ki = 1;
      else begin m_ea = 1; m_mode = 3; m_rem = RS; end
    end else if (p) begin
      m_mode = 1; m_rem = FR - FL;
    end else if (s && m_mode != 0) begin
      if (m_rem == 1) begin
        if (m_mode == 1) begin m_mode = 2; m_rem = FL; m_el = 0; end
        else begin m_mode = 0; m_rem = 0; end
      end else begin
        m_rem--;
        if (m_mode == 2) m_el++;
      end
    end
  endtask

  function automatic logic [6:0] model_out();
    logic sh;
    sh = (m_mode == 1) || (m_mode == 2 && ((m_el / FP) % 2 == 0));
    model_out = {2'(m_mode), sh, m_mode != 3, m_mode == 1 || m_mode == 2, m_ea, m_ki};
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    // Directed table (starts from reset)
    tbl.push_back(row(0,1,0,0, 1,1,1,0,0));                             // pill -> FRIGHT
    for (int i = 0; i < 5; i++) tbl.push_back(row(1,0,0,0, 1,1,1,0,0)); // steady
    tbl.push_back(row(1,0,0,0, 2,1,1,0,0));                             // 6th SOF -> FLASH
    tbl.push_back(row(1,0,0,0, 2,1,1,0,0));
    tbl.push_back(row(1,0,0,0, 2,0,1,0,0));
    tbl.push_back(row(1,0,0,0, 2,0,1,0,0));
    tbl.push_back(row(1,0,0,0, 0,0,1,0,0));                             // flash expiry
    tbl.push_back(row(0,0,1,0, 0,0,1,0,1));                             // killed
    tbl.push_back(row(0,0,0,0, 0,0,1,0,0));
    tbl.push_back(row(0,1,1,0, 0,0,1,0,1));                             // col beats pill
    tbl.push_back(row(0,0,0,0, 0,0,1,0,0));
    tbl.push_back(row(0,1,0,0, 1,1,1,0,0));
    tbl.push_back(row(0,0,1,0, 3,0,0,1,0));                             // eaten
    tbl.push_back(row(0,1,0,0, 3,0,0,0,0));                             // pill ignored
    tbl.push_back(row(1,0,0,0, 3,0,0,0,0));
    tbl.push_back(row(1,0,0,0, 3,0,0,0,0));
    tbl.push_back(row(1,0,0,0, 0,0,1,0,0));                             // respawn
    tbl.push_back(row(1,1,0,0, 1,1,1,0,0));                             // pill replaces tick
    for (int i = 0; i < 5; i++) tbl.push_back(row(1,0,0,0, 1,1,1,0,0));
    tbl.push_back(row(1,0,0,0, 2,1,1,0,0));
    tbl.push_back(row(1,0,0,0, 2,1,1,0,0));
    tbl.push_back(row(1,0,0,0, 2,0,1,0,0));                             // flash count 2
    tbl.push_back(row(0,1,0,0, 1,1,1,0,0));                             // pill -> FRIGHT
    for (int i = 0; i < 5; i++) tbl.push_back(row(1,0,0,0, 1,1,1,0,0)); // full steady again
    tbl.push_back(row(1,0,0,0, 2,1,1,0,0));
    tbl.push_back(row(1,0,1,1, 0,0,1,0,0));                             // restart overrides

    resetN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", actual(), 7'b00_01000);
    @(negedge clk);
    resetN = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].sof, tbl[i].pill, tbl[i].col, tbl[i].rst);
      check($sformatf("table_row_%0d", i), actual(), exp_of(tbl[i]));
    end

    // Async reset in the middle of FLASH
    step(0,1,0,0);
    repeat (6) step(1,0,0,0);
    step(1,0,0,0);
    check("pre_async_reset_flash", actual(), 7'b10_11100);
    @(negedge clk);
    sof = 1'b0; pill = 1'b0; col = 1'b0; rst = 1'b0;
    #2 resetN = 1'b0;
    #1 check("async_reset_immediate", actual(), 7'b00_01000);
    @(negedge clk);
    pill = 1'b1;
    @(posedge clk);
    #1 check("held_in_reset", actual(), 7'b00_01000);
    @(negedge clk);
    pill = 1'b0;
    resetN = 1'b1;
    step(0,0,0,0);
    check("after_reset_release", actual(), 7'b00_01000);

    // Randomized traffic against the reference model
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      bit s, p, c, r;
      s = ($urandom_range(0, 99) < 45);
      p = ($urandom_range(0, 99) < 6);
      c = ($urandom_range(0, 99) < 5);
      r = ($urandom_range(0, 299) == 0);
      step(s, p, c, r);
      model_step(s, p, c, r);
      check($sformatf("random_cycle_%0d", n), actual(), model_out());
      if (monsterEaten && pacmanKilled) begin
        tests++;
        fails++;
        $display("FAIL pulse_exclusive cycle %0d: both pulses high, required at most one", n);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
